// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive controller. Synchronises the serial line, gates
// an external baud generator through Count_Sig, samples on its mid-bit
// BPS_CLK pulse, checks optional parity and the stop bit, and hands bytes
// out through a valid/ack handshake with error and overrun reporting.
module uart_rx_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       RX_Pin_In,
  input  logic       BPS_CLK,
  output logic       Count_Sig,
  output logic [7:0] RX_Data,
  output logic       RX_Valid,
  input  logic       RX_Ack,
  output logic       Frame_Err,
  output logic       Parity_Err,
  output logic       Overrun
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_START    = 3'd1;
  localparam logic [2:0] ST_DATA     = 3'd2;
  localparam logic [2:0] ST_PARITY   = 3'd3;
  localparam logic [2:0] ST_STOP     = 3'd4;
  localparam logic [2:0] ST_BRK_WAIT = 3'd5;

  localparam int         ALIGN    = 8 - DATA_BITS;
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);
  localparam logic       PAR_EN   = (PARITY_EN != 0);
  localparam logic       ODD_BIT  = (PARITY_ODD != 0);

  logic       r_s1, r_s2, r_s3;
  logic [2:0] r_state;
  logic [3:0] r_bitCnt;
  logic [7:0] r_shift;
  logic       r_parBit;
  logic       r_countSig;
  logic [7:0] r_data;
  logic       r_valid;
  logic       r_frameErr;
  logic       r_parityErr;
  logic       r_overrun;

  logic       w_fall;
  logic [7:0] w_rxByte;
  logic       w_parExp;
  logic       w_parBad;
  logic       w_load;

  // Bits arrive LSB-first into the MSB end, so short frames sit in the top
  // bits of the shift register and must be moved down to bit 0.
  assign w_fall   = r_s3 & ~r_s2;
  assign w_rxByte = r_shift >> ALIGN;
  assign w_parExp = (^w_rxByte) ^ ODD_BIT;
  assign w_parBad = PAR_EN & (r_parBit != w_parExp);
  assign w_load   = (r_state == ST_STOP) & BPS_CLK & r_s2 & ~w_parBad;

  assign Count_Sig  = r_countSig;
  assign RX_Data    = r_data;
  assign RX_Valid   = r_valid;
  assign Frame_Err  = r_frameErr;
  assign Parity_Err = r_parityErr;
  assign Overrun    = r_overrun;

  // Three-flop synchroniser on the asynchronous line; idles high.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_s3 <= 1'b1;
    end else begin
      r_s1 <= RX_Pin_In;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Frame FSM: start detection, bit sampling, parity/stop checks, break wait.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state     <= ST_IDLE;
      r_bitCnt    <= 4'd0;
      r_shift     <= 8'd0;
      r_parBit    <= 1'b0;
      r_countSig  <= 1'b0;
      r_frameErr  <= 1'b0;
      r_parityErr <= 1'b0;
    end else begin
      r_frameErr  <= 1'b0;
      r_parityErr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_fall) begin
            r_state    <= ST_START;
            r_countSig <= 1'b1;
          end
        end
        ST_START: begin
          if (BPS_CLK) begin
            if (r_s2) begin
              r_state    <= ST_IDLE;
              r_countSig <= 1'b0;
            end else begin
              r_state  <= ST_DATA;
              r_bitCnt <= 4'd0;
              r_shift  <= 8'd0;
            end
          end
        end
        ST_DATA: begin
          if (BPS_CLK) begin
            r_shift  <= {r_s2, r_shift[7:1]};
            r_bitCnt <= r_bitCnt + 4'd1;
            if (r_bitCnt == LAST_BIT) begin
              r_state <= PAR_EN ? ST_PARITY : ST_STOP;
            end
          end
        end
        ST_PARITY: begin
          if (BPS_CLK) begin
            r_parBit <= r_s2;
            r_state  <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (BPS_CLK) begin
            r_countSig <= 1'b0;
            if (!r_s2) begin
              r_frameErr <= 1'b1;
              r_state    <= ST_BRK_WAIT;
            end else begin
              r_parityErr <= w_parBad;
              r_state     <= ST_IDLE;
            end
          end
        end
        ST_BRK_WAIT: begin
          if (r_s2) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_countSig <= 1'b0;
        end
      endcase
    end
  end

  // Output handshake: load on a good stop bit, clear on ack, flag overruns.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_data    <= 8'd0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_load) begin
      r_data  <= w_rxByte;
      r_valid <= 1'b1;
      if (r_valid && !RX_Ack) begin
        r_overrun <= 1'b1;
      end
    end else if (r_valid && RX_Ack) begin
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed bench for uart_rx_ctrl with a behavioural baud
// generator per instance (shortened bit period), one 8N1 and one 8E1 DUT.
module tb_uart_rx_ctrl;

  localparam int BIT  = 64;
  localparam int HALF = 32;

  logic       CLK;
  logic       RSTn;

  logic       rxLine, bps, countSig, rxValid, rxAck, frameErr, parityErr, overrun;
  logic [7:0] rxData;
  logic       rxLineP, bpsP, countSigP, rxValidP, rxAckP, frameErrP, parityErrP, overrunP;
  logic [7:0] rxDataP;

  int checks = 0;
  int errors = 0;

  int baudCnt  = 0;
  int baudCntP = 0;
  int cyc = 0;
  int lastBpsCyc = 0;
  int validRiseCyc = 0;
  logic prevValid = 1'b0;
  int bpsCnt = 0;
  int frameErrCnt = 0;
  int parityErrCnt = 0;
  int frameErrCntP = 0;
  int parityErrCntP = 0;

  uart_rx_ctrl dut (
    .CLK(CLK), .RSTn(RSTn), .RX_Pin_In(rxLine), .BPS_CLK(bps),
    .Count_Sig(countSig), .RX_Data(rxData), .RX_Valid(rxValid), .RX_Ack(rxAck),
    .Frame_Err(frameErr), .Parity_Err(parityErr), .Overrun(overrun)
  );

  uart_rx_ctrl #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dutP (
    .CLK(CLK), .RSTn(RSTn), .RX_Pin_In(rxLineP), .BPS_CLK(bpsP),
    .Count_Sig(countSigP), .RX_Data(rxDataP), .RX_Valid(rxValidP), .RX_Ack(rxAckP),
    .Frame_Err(frameErrP), .Parity_Err(parityErrP), .Overrun(overrunP)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Baud generators: count while enabled, pulse once per bit at mid-bit.
  always @(posedge CLK) begin
    baudCnt  <= !countSig  ? 0 : (baudCnt  == BIT - 1) ? 0 : baudCnt  + 1;
    baudCntP <= !countSigP ? 0 : (baudCntP == BIT - 1) ? 0 : baudCntP + 1;
    cyc <= cyc + 1;
  end
  assign bps  = countSig  && (baudCnt  == HALF - 1);
  assign bpsP = countSigP && (baudCntP == HALF - 1);

  // Event monitor: pulse counts and timing of the valid rise.
  always @(negedge CLK) begin
    if (bps) begin
      lastBpsCyc <= cyc;
      bpsCnt <= bpsCnt + 1;
    end
    if (rxValid && !prevValid) validRiseCyc <= cyc;
    prevValid <= rxValid;
    if (frameErr)   frameErrCnt   <= frameErrCnt + 1;
    if (parityErr)  parityErrCnt  <= parityErrCnt + 1;
    if (frameErrP)  frameErrCntP  <= frameErrCntP + 1;
    if (parityErrP) parityErrCntP <= parityErrCntP + 1;
  end

  task automatic setLine(input logic b, input bit toPar);
    if (toPar) rxLineP = b;
    else       rxLine  = b;
  endtask

  task automatic driveBit(input logic b, input bit toPar);
    setLine(b, toPar);
    repeat (BIT) @(negedge CLK);
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic stopBit, input bit toPar,
                           input bit withPar, input logic parBit);
    driveBit(1'b0, toPar);
    for (int i = 0; i < 8; i++) driveBit(d[i], toPar);
    if (withPar) driveBit(parBit, toPar);
    driveBit(stopBit, toPar);
  endtask

  task automatic ackMain();
    rxAck = 1'b1;
    @(negedge CLK);
    rxAck = 1'b0;
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    repeat (3) @(negedge CLK);
    checks++; if (countSig !== 1'b0) begin errors++; $display("[TB] FAIL reset Count_Sig: got %b expected 0", countSig); end
    checks++; if (rxData !== 8'h00) begin errors++; $display("[TB] FAIL reset RX_Data: got %h expected 00", rxData); end
    checks++; if (rxValid !== 1'b0) begin errors++; $display("[TB] FAIL reset RX_Valid: got %b expected 0", rxValid); end
    checks++; if (frameErr !== 1'b0) begin errors++; $display("[TB] FAIL reset Frame_Err: got %b expected 0", frameErr); end
    checks++; if (parityErr !== 1'b0) begin errors++; $display("[TB] FAIL reset Parity_Err: got %b expected 0", parityErr); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset Overrun: got %b expected 0", overrun); end
    checks++; if (rxValidP !== 1'b0) begin errors++; $display("[TB] FAIL reset RX_Valid parity dut: got %b expected 0", rxValidP); end
    RSTn = 1'b1;
    repeat (BIT) @(negedge CLK);
  endtask

  task automatic test_basic();
    int fe0 = frameErrCnt;
    int pe0 = parityErrCnt;
    sendFrame(8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge CLK);
    checks++; if (rxValid !== 1'b1) begin errors++; $display("[TB] FAIL basic RX_Valid: got %b expected 1", rxValid); end
    checks++; if (rxData !== 8'h55) begin errors++; $display("[TB] FAIL basic RX_Data: got %h expected 55", rxData); end
    checks++; if (validRiseCyc !== lastBpsCyc + 1) begin errors++; $display("[TB] FAIL basic valid latency: got cycle %0d expected %0d", validRiseCyc, lastBpsCyc + 1); end
    checks++; if (frameErrCnt !== fe0) begin errors++; $display("[TB] FAIL basic Frame_Err pulses: got %0d expected %0d", frameErrCnt, fe0); end
    checks++; if (parityErrCnt !== pe0) begin errors++; $display("[TB] FAIL basic Parity_Err pulses: got %0d expected %0d", parityErrCnt, pe0); end
    checks++; if (countSig !== 1'b0) begin errors++; $display("[TB] FAIL basic Count_Sig after stop: got %b expected 0", countSig); end
    ackMain();
    checks++; if (rxValid !== 1'b0) begin errors++; $display("[TB] FAIL basic RX_Valid after ack: got %b expected 0", rxValid); end
  endtask

  task automatic test_glitch();
    int fe0 = frameErrCnt;
    int b0 = bpsCnt;
    setLine(1'b0, 1'b0);
    repeat (10) @(negedge CLK);
    checks++; if (countSig !== 1'b1) begin errors++; $display("[TB] FAIL glitch Count_Sig during low: got %b expected 1", countSig); end
    repeat (10) @(negedge CLK);
    setLine(1'b1, 1'b0);
    repeat (100) @(negedge CLK);
    checks++; if (countSig !== 1'b0) begin errors++; $display("[TB] FAIL glitch Count_Sig after: got %b expected 0", countSig); end
    checks++; if (bpsCnt !== b0 + 1) begin errors++; $display("[TB] FAIL glitch BPS pulses: got %0d expected %0d", bpsCnt, b0 + 1); end
    checks++; if (rxValid !== 1'b0) begin errors++; $display("[TB] FAIL glitch RX_Valid: got %b expected 0", rxValid); end
    checks++; if (frameErrCnt !== fe0) begin errors++; $display("[TB] FAIL glitch Frame_Err pulses: got %0d expected %0d", frameErrCnt, fe0); end
  endtask

  task automatic test_frame_err();
    int fe0 = frameErrCnt;
    int pe0 = parityErrCnt;
    sendFrame(8'hA3, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (200) @(negedge CLK);
    checks++; if (countSig !== 1'b0) begin errors++; $display("[TB] FAIL break Count_Sig mid-break: got %b expected 0", countSig); end
    repeat (200) @(negedge CLK);
    checks++; if (countSig !== 1'b0) begin errors++; $display("[TB] FAIL break Count_Sig end-break: got %b expected 0", countSig); end
    checks++; if (frameErrCnt !== fe0 + 1) begin errors++; $display("[TB] FAIL break Frame_Err pulses: got %0d expected %0d", frameErrCnt, fe0 + 1); end
    checks++; if (parityErrCnt !== pe0) begin errors++; $display("[TB] FAIL break Parity_Err pulses: got %0d expected %0d", parityErrCnt, pe0); end
    checks++; if (rxValid !== 1'b0) begin errors++; $display("[TB] FAIL break RX_Valid: got %b expected 0", rxValid); end
    setLine(1'b1, 1'b0);
    repeat (2 * BIT) @(negedge CLK);
    sendFrame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge CLK);
    checks++; if (rxValid !== 1'b1) begin errors++; $display("[TB] FAIL break next RX_Valid: got %b expected 1", rxValid); end
    checks++; if (rxData !== 8'h3C) begin errors++; $display("[TB] FAIL break next RX_Data: got %h expected 3c", rxData); end
    checks++; if (frameErrCnt !== fe0 + 1) begin errors++; $display("[TB] FAIL break next Frame_Err pulses: got %0d expected %0d", frameErrCnt, fe0 + 1); end
    ackMain();
  endtask

  task automatic test_back_to_back();
    sendFrame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (rxData !== 8'h11) begin errors++; $display("[TB] FAIL b2b first RX_Data: got %h expected 11", rxData); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL b2b first Overrun: got %b expected 0", overrun); end
    sendFrame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge CLK);
    checks++; if (rxData !== 8'h22) begin errors++; $display("[TB] FAIL b2b RX_Data: got %h expected 22", rxData); end
    checks++; if (rxValid !== 1'b1) begin errors++; $display("[TB] FAIL b2b RX_Valid: got %b expected 1", rxValid); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL b2b Overrun: got %b expected 1", overrun); end
    ackMain();
    checks++; if (rxValid !== 1'b0) begin errors++; $display("[TB] FAIL b2b RX_Valid after ack: got %b expected 0", rxValid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL b2b Overrun after ack: got %b expected 0", overrun); end
  endtask

  task automatic test_parity();
    int fe0 = frameErrCntP;
    int pe0 = parityErrCntP;
    // 0x07 has three ones, so even parity needs a parity bit of 1.
    sendFrame(8'h07, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (2) @(negedge CLK);
    checks++; if (parityErrCntP !== pe0 + 1) begin errors++; $display("[TB] FAIL parity bad Parity_Err pulses: got %0d expected %0d", parityErrCntP, pe0 + 1); end
    checks++; if (rxValidP !== 1'b0) begin errors++; $display("[TB] FAIL parity bad RX_Valid: got %b expected 0", rxValidP); end
    checks++; if (frameErrCntP !== fe0) begin errors++; $display("[TB] FAIL parity bad Frame_Err pulses: got %0d expected %0d", frameErrCntP, fe0); end
    sendFrame(8'h07, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (2) @(negedge CLK);
    checks++; if (rxValidP !== 1'b1) begin errors++; $display("[TB] FAIL parity good RX_Valid: got %b expected 1", rxValidP); end
    checks++; if (rxDataP !== 8'h07) begin errors++; $display("[TB] FAIL parity good RX_Data: got %h expected 07", rxDataP); end
    checks++; if (parityErrCntP !== pe0 + 1) begin errors++; $display("[TB] FAIL parity good Parity_Err pulses: got %0d expected %0d", parityErrCntP, pe0 + 1); end
  endtask

  task automatic test_reset_mid_frame();
    int fe0;
    int pe0;
    driveBit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) driveBit(1'b0, 1'b0);
    setLine(1'b1, 1'b0);
    repeat (10) @(negedge CLK);
    RSTn = 1'b0;
    repeat (3) @(negedge CLK);
    checks++; if (countSig !== 1'b0) begin errors++; $display("[TB] FAIL midreset Count_Sig: got %b expected 0", countSig); end
    checks++; if (rxData !== 8'h00) begin errors++; $display("[TB] FAIL midreset RX_Data: got %h expected 00", rxData); end
    checks++; if (rxValid !== 1'b0) begin errors++; $display("[TB] FAIL midreset RX_Valid: got %b expected 0", rxValid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL midreset Overrun: got %b expected 0", overrun); end
    checks++; if (frameErr !== 1'b0) begin errors++; $display("[TB] FAIL midreset Frame_Err: got %b expected 0", frameErr); end
    checks++; if (rxValidP !== 1'b0) begin errors++; $display("[TB] FAIL midreset parity dut RX_Valid: got %b expected 0", rxValidP); end
    checks++; if (rxDataP !== 8'h00) begin errors++; $display("[TB] FAIL midreset parity dut RX_Data: got %h expected 00", rxDataP); end
    RSTn = 1'b1;
    repeat (4 * BIT) @(negedge CLK);
    fe0 = frameErrCnt;
    pe0 = parityErrCnt;
    sendFrame(8'h81, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge CLK);
    checks++; if (rxData !== 8'h81) begin errors++; $display("[TB] FAIL midreset next RX_Data: got %h expected 81", rxData); end
    checks++; if (rxValid !== 1'b1) begin errors++; $display("[TB] FAIL midreset next RX_Valid: got %b expected 1", rxValid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL midreset next Overrun: got %b expected 0", overrun); end
    checks++; if (frameErrCnt !== fe0) begin errors++; $display("[TB] FAIL midreset next Frame_Err pulses: got %0d expected %0d", frameErrCnt, fe0); end
    checks++; if (parityErrCnt !== pe0) begin errors++; $display("[TB] FAIL midreset next Parity_Err pulses: got %0d expected %0d", parityErrCnt, pe0); end
  endtask

  // Test sequence.
  initial begin
    rxLine  = 1'b1;
    rxLineP = 1'b1;
    rxAck   = 1'b0;
    rxAckP  = 1'b0;
    RSTn    = 1'b0;
    @(negedge CLK);
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_parity();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side controller for the UART RX path. It synchronises the serial input and detects the start-bit falling edge. It gates the baud-rate generator through Count_Sig and samples each bit on the generator's mid-bit BPS_CLK pulse. It assembles the frame LSB-first, checks the optional parity bit and the stop bit, and delivers bytes through a valid/ack handshake with error and overrun flags.

Parameters:
DATA_BITS, 8, data bits per frame (5..8); RX_Data bits above DATA_BITS are driven 0.
PARITY_EN, 0, 1 = a parity bit follows the data bits.
PARITY_ODD, 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN=0.

Ports:
CLK  input  1  system clock (50 MHz)
RSTn  input  1  asynchronous active-low reset
RX_Pin_In  input  1  asynchronous serial line, idle high
BPS_CLK  input  1  one-CLK pulse at mid-bit from the baud generator
Count_Sig  output  1  enables the baud generator counter; low holds it at 0
RX_Data  output  8  last accepted byte
RX_Valid  output  1  RX_Data holds an unacknowledged byte
RX_Ack  input  1  consumer accepts byte (effective only while RX_Valid=1)
Frame_Err  output  1  one-CLK pulse: stop bit sampled 0
Parity_Err  output  1  one-CLK pulse: parity mismatch
Overrun  output  1  sticky: a new byte overwrote an unacknowledged one

Behaviour:
- Reset is asynchronous, active-low, on RSTn; clock is CLK. Reset values: all outputs 0, state IDLE, shift register 0, synchroniser flops 1.
- Synchroniser: three flops s1→s2→s3 on RX_Pin_In. fall = s3 & ~s2. All bit sampling uses s2.
- States: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
- IDLE:
  - On fall: go to START and register Count_Sig=1.
  - Count_Sig rises on the 3rd CLK edge after the first edge that samples RX_Pin_In low.
- START: on BPS_CLK, sample s2.
  - s2=1 (glitch/false start): go to IDLE, Count_Sig=0.
  - s2=0: go to DATA, clear the bit counter.
- DATA: on each BPS_CLK, shift s2 into the MSB end (LSB-first frame) and increment the bit counter.
  - After the DATA_BITS-th sample, go to PARITY if PARITY_EN=1, else STOP.
- PARITY: on BPS_CLK, capture s2. Expected value = XOR of data bits, XOR PARITY_ODD. Go to STOP.
- STOP: on BPS_CLK, sample s2 and drop Count_Sig the next cycle.
  - s2=0: Frame_Err pulses; byte discarded; go to BRK_WAIT.
  - s2=1 with parity mismatch: Parity_Err pulses; byte discarded; go to IDLE.
  - s2=1 with good parity: load RX_Data and set RX_Valid (1 CLK after the stop BPS_CLK); go to IDLE.
  - A new start edge is accepted from the cycle after IDLE is re-entered, i.e. from mid-stop-bit onward.
- BRK_WAIT: stay until s2=1, then go to IDLE. Line-break or stuck-low never retriggers reception.
- BPS_CLK outside START/DATA/PARITY/STOP is ignored.
- Handshake:
  - RX_Valid stays 1 until a cycle with RX_Ack=1 and RX_Valid=1; it clears on the next edge.
  - Byte load while RX_Valid=1 with no ack in that cycle: RX_Data is overwritten, RX_Valid stays 1, Overrun is set.
  - Ack and byte load in the same cycle: the new byte is loaded, RX_Valid stays 1, Overrun is unchanged.
  - Overrun clears on an accepted ack unless it is being set in the same cycle.
- Frame_Err and Parity_Err never both pulse for one frame; framing takes priority.
- RSTn asserted mid-frame: immediate return to reset values; Count_Sig=0 (baud counter clears). The first frame after release is received normally.

Test Plan:
1. 8N1 frame 0x55 at 5208 CLK/bit through the baud generator → RX_Valid=1, RX_Data=0x55 one CLK after the stop-bit BPS_CLK; RX_Ack pulse → RX_Valid=0 next cycle; no error pulses.
2. RX_Pin_In low for 1000 CLK, then high → Count_Sig high until the first BPS_CLK, then 0; state IDLE; no RX_Valid, no error pulses.
3. Frame 0xA3 with stop bit 0, line held low 20000 CLK, then 0x3C 8N1 → one Frame_Err pulse; no RX_Valid for 0xA3; no restart while low; RX_Data=0x3C with RX_Valid=1.
4. Frames 0x11 then 0x22 back-to-back, no ack → RX_Data=0x22, RX_Valid=1, Overrun=1; RX_Ack → RX_Valid=0, Overrun=0.
5. PARITY_EN=1, PARITY_ODD=0, data 0x07 with parity bit 0 → Parity_Err pulse, no RX_Valid; same data with parity bit 1 → RX_Valid=1, RX_Data=0x07.
6. RSTn low during data bit 4 of 0xF0, released, then 0x81 sent → all outputs 0 during reset, Count_Sig=0; afterwards RX_Data=0x81, RX_Valid=1, no error flags.
